// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// One shared add/subtract per cycle: shift-add multiply, restoring divide.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t state, state_next;

  logic [1:0]         op_r;
  logic               sign_a, sign_b, div_zero;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic               is_div;
  logic               in_signed, in_divzero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     add_x, add_y;
  logic               add_cin;
  logic [WIDTH+1:0]   add_sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] prod;

  assign is_div = op_r[1];
  assign busy   = (state != IDLE);
  assign done   = done_r;
  assign hi     = hi_r;
  assign lo     = lo_r;

  // Operand conditioning at the start edge. A zero divisor keeps the raw
  // dividend so the unsigned restoring result (hi = a) falls out naturally.
  always_comb begin
    in_signed  = ~op[0];
    in_divzero = op[1] && (b == '0);
    mag_a      = (in_signed && a[WIDTH-1] && !in_divzero) ? -a : a;
    mag_b      = (in_signed && b[WIDTH-1]) ? -b : b;
  end

  // Single shared adder: multiply adds the multiplicand to the upper half,
  // divide subtracts the divisor from the shifted remainder (carry = no borrow).
  always_comb begin
    add_x   = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_y   = is_div ? ~{1'b0, opnd} : {1'b0, opnd};
    add_cin = is_div;
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
  end

  always_comb begin
    acc_step = acc;
    if (is_div) begin
      if (add_sum[WIDTH+1])
        acc_step = {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0])
        acc_step = {add_sum[WIDTH:0], acc[WIDTH-1:1]};
      else
        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // Sign correction applied only in the final cycle, never on a zero divisor.
  always_comb begin
    prod = acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (!is_div) begin
      if (!op_r[0] && (sign_a ^ sign_b))
        prod = -acc;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else begin
      if (!op_r[0] && !div_zero) begin
        if (sign_a ^ sign_b)
          quo = -acc[WIDTH-1:0];
        if (sign_a)
          rem = -acc[2*WIDTH-1:WIDTH];
      end
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = ITER;
      ITER: if (cnt == CW'(WIDTH-1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      cnt      <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            op_r     <= op;
            sign_a   <= a[WIDTH-1];
            sign_b   <= b[WIDTH-1];
            div_zero <= in_divzero;
            opnd     <= mag_b;
            acc      <= op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_a};
            cnt      <= '0;
          end
        end
        ITER: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO change only on an idle MTHI/MTLO or on the final result write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (state == FIX) begin
      hi_r <= res_hi;
      lo_r <= res_lo;
    end else if (state == IDLE) begin
      if (hi_we) hi_r <= wdata;
      if (lo_we) lo_r <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO pushed at start, popped on done.
module tb_muldiv_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] sbq[$];

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W), .CW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (o)
      2'b00: res = sx * sy;
      2'b01: res = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    sbq.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt, output bit seen);
    lat = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (busy === 1'b1) busy_cnt++;
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic pop_exp(output logic [63:0] e);
    if (sbq.size() == 0) e = 'x;
    else e = sbq.pop_front();
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== '0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== '0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    reset = 1'b0;
  endtask

  task automatic test_mthi_mtlo;
    logic [63:0] e; int lat, bc; bit seen;
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL mthi: got %h expected deadbeef", hi); end
    checks++; if (lo !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL mtlo: got %h expected deadbeef", lo); end
    // MTHI in the same cycle as start: lands now, overwritten by the result later.
    @(negedge clk);
    op = 2'b01; a = 6; b = 7; start = 1'b1; hi_we = 1'b1; wdata = 32'h1111;
    sbq.push_back(model(2'b01, 6, 7));
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checks++; if (hi !== 32'h1111) begin errors++; $display("[TB] FAIL mthi_with_start: got %h expected 00001111", hi); end
    wait_done(lat, bc, seen);
    pop_exp(e);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL mthi_start_done: timeout, got no done"); end
    checks++; if (hi !== e[63:32]) begin errors++; $display("[TB] FAIL mthi_start_hi: got %h expected %h", hi, e[63:32]); end
    checks++; if (lo !== e[31:0]) begin errors++; $display("[TB] FAIL mthi_start_lo: got %h expected %h", lo, e[31:0]); end
  endtask

  task automatic test_multu_latency;
    logic [63:0] e; int lat, bc; bit seen;
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc, seen);
    pop_exp(e);
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL multu_latency: got %0d expected 33", lat); end
    checks++; if (bc !== 33) begin errors++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 33", bc); end
    checks++; if (hi !== e[63:32]) begin errors++; $display("[TB] FAIL multu_hi: got %h expected %h", hi, e[63:32]); end
    checks++; if (lo !== e[31:0]) begin errors++; $display("[TB] FAIL multu_lo: got %h expected %h", lo, e[31:0]); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL multu_done_width: got %b expected 0", done); end
  endtask

  // Signed cases plus divide-by-zero and the -2^31 / -1 wrap.
  task automatic test_signed_and_edges;
    logic [1:0]  tops[8] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10};
    logic [31:0] ta[8]   = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000, 32'h7, 32'hFFFFFFFF, 32'd100, 32'h80000000, 32'hFFFFFF9C};
    logic [31:0] tb[8]   = '{32'd5, 32'd2, 32'h80000000, 32'hFFFFFFFE, 32'd10, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [63:0] e; int lat, bc; bit seen;
    for (int i = 0; i < 8; i++) begin
      do_op(tops[i], ta[i], tb[i]);
      wait_done(lat, bc, seen);
      pop_exp(e);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL edge%0d_done: timeout, got no done", i); end
      checks++; if (hi !== e[63:32]) begin errors++; $display("[TB] FAIL edge%0d_hi: got %h expected %h", i, hi, e[63:32]); end
      checks++; if (lo !== e[31:0]) begin errors++; $display("[TB] FAIL edge%0d_lo: got %h expected %h", i, lo, e[31:0]); end
    end
  endtask

  task automatic test_random;
    logic [63:0] e; int lat, bc; bit seen;
    logic [31:0] x, y;
    for (int i = 0; i < 10; i++) begin
      x = $urandom;
      y = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      do_op(2'($urandom_range(0, 3)), x, y);
      wait_done(lat, bc, seen);
      pop_exp(e);
      checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected 33", i, lat); end
      checks++; if ({hi, lo} !== e) begin errors++; $display("[TB] FAIL rand%0d_result: got %h expected %h", i, {hi, lo}, e); end
    end
  endtask

  task automatic test_busy_ignore;
    logic [63:0] e; int lat, bc, pulses; bit seen;
    logic [31:0] hi_before;
    hi_before = hi;
    do_op(2'b11, 32'd1000, 32'd7);
    repeat (4) @(negedge clk);
    op = 2'b01; a = 3; b = 3; start = 1'b1; hi_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checks++; if (hi !== hi_before) begin errors++; $display("[TB] FAIL busy_mthi: got %h expected %h", hi, hi_before); end
    wait_done(lat, bc, seen);
    pop_exp(e);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL busy_done: timeout, got no done"); end
    checks++; if (lo !== e[31:0]) begin errors++; $display("[TB] FAIL busy_lo: got %h expected %h", lo, e[31:0]); end
    checks++; if (hi !== e[63:32]) begin errors++; $display("[TB] FAIL busy_hi: got %h expected %h", hi, e[63:32]); end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL busy_extra_done: got %0d expected 0", pulses); end
  endtask

  task automatic test_reset_abort;
    int pulses;
    @(negedge clk);
    op = 2'b01; a = 32'h1234; b = 32'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("[TB] FAIL abort_hilo: got %h expected 0", {hi, lo}); end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL abort_late_done: got %0d expected 0", pulses); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("[TB] FAIL abort_hilo_after: got %h expected 0", {hi, lo}); end
    lo_we = 1'b1; wdata = 32'hABCD;
    @(negedge clk);
    lo_we = 1'b0;
    checks++; if (lo !== 32'hABCD) begin errors++; $display("[TB] FAIL abort_mtlo: got %h expected 0000abcd", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL abort_mtlo_hi: got %h expected 0", hi); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] e; int lat, bc; bit seen;
    do_op(2'b01, 32'd12345, 32'd6789);
    wait_done(lat, bc, seen);
    pop_exp(e);
    checks++; if ({hi, lo} !== e) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", {hi, lo}, e); end
    op = 2'b10; a = 32'hFFFFFC18; b = 32'd33; start = 1'b1;
    sbq.push_back(model(2'b10, 32'hFFFFFC18, 32'd33));
    @(negedge clk);
    start = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_width: got %b expected 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
    wait_done(lat, bc, seen);
    pop_exp(e);
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 33", lat); end
    checks++; if ({hi, lo} !== e) begin errors++; $display("[TB] FAIL b2b_second: got %h expected %h", {hi, lo}, e); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_end: got %b expected 0", done); end
  endtask

  initial begin
    test_reset;
    test_mthi_mtlo;
    test_multu_latency;
    test_signed_and_edges;
    test_random;
    test_busy_ignore;
    test_reset_abort;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
